alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one 32-bit ALU datapath among NREQ requesters (e.g. main pipeline, address generator, multicycle sequencer) using fair round-robin arbitration. Each requester uses a valid/ready handshake. One operation is in flight at a time. The result is returned on a registered response channel with the requester ID and supports backpressure. The block sits between the requesting units and the single shared alu instance.

Parameters:
NREQ, 4, number of requesters; legal range 2..8.
ID_W, $clog2(NREQ), localparam; width of requester ID.

Ports:
clk  input  1  single clock; all logic on rising edge.
reset_n  input  1  asynchronous, active-low reset.
req_valid  input  NREQ  per-requester operation valid.
req_a  input  NREQ*32  flattened operand A; slot i = bits [32*i+31:32*i].
req_b  input  NREQ*32  flattened operand B, same packing.
req_alucont  input  NREQ*3  flattened ALU control, 3 bits per slot.
req_ready  output  NREQ  one-hot grant; the op is accepted when valid&ready.
rsp_valid  output  1  response valid.
rsp_ready  input  1  consumer accepts the response.
rsp_id  output  ID_W  index of the requester that issued the op.
rsp_result  output  32  ALU result.
rsp_zero  output  1  result == 0.
rsp_err  output  1  alucont was not a legal code.
busy  output  1  state != IDLE.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, busy=0.
- Legal alucont codes: 010 add, 110 sub, 000 and, 001 or, 111 slt. slt is an unsigned compare, giving 1 or 0.
- State IDLE:
  - req_ready is combinational. It is one-hot for the first set req_valid bit searching from rr_ptr upward, wrapping modulo NREQ. It is all zero when no request is valid.
  - On handshake, latch a, b, alucont and id into operand registers, then go to EXEC.
- State EXEC, exactly 1 cycle:
  - The registered operands drive the alu.
  - Capture result and zero into the rsp_* registers.
  - rsp_err = 1 if alucont is illegal. In that case rsp_result=0 and rsp_zero=1, never X.
  - rr_ptr <= (granted id + 1) mod NREQ. Go to RESP.
- State RESP:
  - rsp_valid=1. The rsp_* outputs are held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready, go to IDLE and drop rsp_valid the next cycle.
- Timing: latency is handshake at cycle T, rsp_valid at T+2. Peak throughput is one op per 3 cycles.
- req_ready is 0 in EXEC and RESP. Requesters must hold valid and operands stable until granted; a drop before the grant is legal and simply not accepted.
- Simultaneous requests: only one is granted per IDLE cycle. Any requester continuously requesting is granted within NREQ operations (starvation-free).
- Single requester: back-to-back grants to the same id are allowed, since the pointer wraps past it and returns.
- Reset mid-operation: asynchronous assertion aborts any EXEC or RESP. The in-flight op is discarded and all outputs return to their reset values immediately.
- rsp_ready asserted while rsp_valid=0 is ignored.

Optional Feature:
ALU_ARBITER_STATS_EN
- Defined: adds output ports grant_cnt (NREQ*16, flattened) and stall_cnt (16).
  - grant_cnt[i] increments on each accepted op from requester i.
  - stall_cnt increments each cycle in RESP with rsp_ready=0.
  - All counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package alu_arbiter_pkg holds:
  - alucont constants ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_AND=3'b000, ALU_OR=3'b001, ALU_SLT=3'b111;
  - function alucont_legal();
  - state enum {IDLE, EXEC, RESP}.
- One sub-module, rr_pick: a combinational round-robin priority encoder (inputs valid vector and pointer; outputs one-hot grant and id).
- The existing 32-bit alu datapath is instantiated unchanged.

Test Plan:
- Reset, then req0 add a=5 b=7 with rsp_ready=1. Expect grant at T, rsp_valid at T+2 with id=0, result=12, zero=0, err=0.
- req2 sub a=9 b=9. Expect result=0 and zero=1; slt a=3 b=8 gives result=1; slt a=0xFFFFFFFF b=1 gives result=0 (unsigned).
- All 4 requesters valid continuously from rr_ptr=0. Expect grant order 0,1,2,3,0, with each id appearing exactly once per 4 responses.
- rsp_ready=0 for 5 cycles after rsp_valid on op and a=0xF0 b=0x3C. Expect result=0x30 held stable, req_ready=0 throughout, and IDLE one cycle after rsp_ready=1.
- req1 with alucont=3'b011. Expect rsp_err=1, result=0, zero=1, id=1.
- Assert reset_n=0 during RESP. Expect rsp_valid=0 and busy=0 immediately; after release, the first request is served from rr_ptr=0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU control codes, legality check, arbiter state encoding and operand bundle.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_arbiter_pkg;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  alucont;
    } op_t;

    function automatic logic alucont_legal(input logic [2:0] code);
        case (code)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit ALU datapath: add, sub, and, or, unsigned set-less-than.
// Latency: combinational.
// Backpressure: none; outputs follow inputs.
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  alucont,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (alucont)
            3'b010:  result = a + b;
            3'b110:  result = a - b;
            3'b000:  result = a & b;
            3'b001:  result = a | b;
            3'b111:  result = {31'd0, (a < b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Round-robin priority encoder: first valid bit at or above ptr, wrapping modulo NREQ.
// Latency: combinational.
// Backpressure: none; grant is all-zero when nothing is valid.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] id,
    output logic            any
);

    logic [NREQ-1:0] rot;
    logic [ID_W:0]   sum;

    always_comb begin
        // rot[k] is requester (ptr + k) mod NREQ
        rot   = NREQ'({valid, valid} >> ptr);
        grant = '0;
        id    = '0;
        any   = 1'b0;
        sum   = '0;
        // Descending scan so the lowest offset from ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (ID_W + 1)'(k);
                any = 1'b1;
            end
        end
        if (sum >= (ID_W + 1)'(NREQ)) begin
            sum = sum - (ID_W + 1)'(NREQ);
        end
        id = sum[ID_W-1:0];
        if (any) begin
            grant[id] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU among NREQ requesters; ALU_ARBITER_STATS_EN adds grant/stall counters.
// Latency: handshake at T, rsp_valid at T+2; one op in flight, peak one op per 3 cycles.
// Backpressure: rsp_* held while rsp_ready=0; req_ready stays low until the response is taken.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*3-1:0] req_alucont,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [31:0]       rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
`ifdef ALU_ARBITER_STATS_EN
    output logic [NREQ*16-1:0] grant_cnt,
    output logic [15:0]       stall_cnt,
`endif
    output logic              busy
);

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] id_q;
    logic [NREQ-1:0] gnt;
    logic            gnt_any;
    logic            hs;
    op_t             op_sel;
    op_t             op_q;
    logic [31:0]     alu_result;
    logic            alu_zero;
    logic            op_legal;

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .id    (gnt_id),
        .any   (gnt_any)
    );

    assign hs = (state == IDLE) && gnt_any;

    always_comb begin
        op_sel         = '0;
        op_sel.a       = req_a[32*gnt_id +: 32];
        op_sel.b       = req_b[32*gnt_id +: 32];
        op_sel.alucont = req_alucont[3*gnt_id +: 3];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = gnt;
                if (hs) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= '0;
            id_q <= '0;
        end else if (hs) begin
            op_q <= op_sel;
            id_q <= gnt_id;
        end
    end

    alu u_alu (
        .a       (op_q.a),
        .b       (op_q.b),
        .alucont (op_q.alucont),
        .result  (alu_result),
        .zero    (alu_zero)
    );

    assign op_legal = alucont_legal(op_q.alucont);

    // Illegal codes report a clean zero result regardless of what the ALU produced.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            rr_ptr     <= '0;
        end else if (state == EXEC) begin
            rsp_id     <= id_q;
            rsp_result <= op_legal ? alu_result : 32'd0;
            rsp_zero   <= op_legal ? alu_zero : 1'b1;
            rsp_err    <= !op_legal;
            rr_ptr     <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
        end
    end

`ifdef ALU_ARBITER_STATS_EN
    logic [15:0] gcnt [NREQ];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) begin
                gcnt[i] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (hs && (gnt_id == ID_W'(i)) && (gcnt[i] != CNT_MAX)) begin
                    gcnt[i] <= gcnt[i] + 16'd1;
                end
            end
            if ((state == RESP) && !rsp_ready && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_cnt_flat
        assign grant_cnt[16*i +: 16] = gcnt[i];
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a cycle-level reference model and literal spot checks.
module tb_alu_arbiter;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*32-1:0] req_a = '0;
    logic [NREQ*32-1:0] req_b = '0;
    logic [NREQ*3-1:0] req_alucont = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [ID_W-1:0]   rsp_id;
    logic [31:0]       rsp_result;
    logic              rsp_zero;
    logic              rsp_err;
    logic              busy;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_alucont (req_alucont),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cmp_n = 0;
    int bad_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: spec-level ALU semantics.
    task automatic ref_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output logic e);
        e = 1'b0;
        case (c)
            3'b010:  r = a + b;
            3'b110:  r = a - b;
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b111:  r = (a < b) ? 32'd1 : 32'd0;
            default: begin r = 32'd0; e = 1'b1; end
        endcase
        z = (r == 32'd0);
    endtask

    function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] v, input int p);
        logic [NREQ-1:0] g = '0;
        for (int off = 0; off < NREQ; off++) begin
            if (v[(p + off) % NREQ]) begin
                g[(p + off) % NREQ] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // Model state: 0 = nothing in flight, 1 = op granted last edge, 2 = response visible.
    int          m_stage = 0;
    int          m_ptr = 0;
    int          m_gid = 0;
    logic [31:0] m_res;
    logic        m_z, m_e;

    int          obs_id[$];
    logic [31:0] obs_res[$];
    logic        obs_z[$];
    logic        obs_e[$];

    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        if (!reset_n) begin
            m_stage = 0;
            m_ptr   = 0;
            check("rst_req_ready", req_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_id", rsp_id, 0);
            check("rst_rsp_result", rsp_result, 0);
            check("rst_rsp_zero", rsp_zero, 0);
            check("rst_rsp_err", rsp_err, 0);
        end else begin
            er = (m_stage == 0) ? pick(req_valid, m_ptr) : '0;
            check("req_ready", req_ready, er);
            check("busy", busy, (m_stage != 0));
            check("rsp_valid", rsp_valid, (m_stage == 2));
            if (m_stage == 2) begin
                check("rsp_id", rsp_id, m_gid);
                check("rsp_result", rsp_result, m_res);
                check("rsp_zero", rsp_zero, m_z);
                check("rsp_err", rsp_err, m_e);
            end
            if (rsp_valid && rsp_ready) begin
                obs_id.push_back(int'(rsp_id));
                obs_res.push_back(rsp_result);
                obs_z.push_back(rsp_zero);
                obs_e.push_back(rsp_err);
            end
            case (m_stage)
                0: if (er != '0) begin
                    for (int k = 0; k < NREQ; k++) if (er[k]) m_gid = k;
                    ref_op(req_alucont[3*m_gid +: 3], req_a[32*m_gid +: 32], req_b[32*m_gid +: 32],
                           m_res, m_z, m_e);
                    m_stage = 1;
                end
                1: begin
                    m_stage = 2;
                    m_ptr   = (m_gid + 1) % NREQ;
                end
                2: if (rsp_ready) m_stage = 0;
                default: m_stage = 0;
            endcase
        end
    end

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        req_a[32*i +: 32]     = a;
        req_b[32*i +: 32]     = b;
        req_alucont[3*i +: 3] = c;
        req_valid[i]          = 1'b1;
    endtask

    // Drops each valid bit once its handshake has been seen.
    task automatic wait_drop(input logic [NREQ-1:0] m);
        logic [NREQ-1:0] hs;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~hs;
            if ((req_valid & m) == '0) return;
        end
        check("grant_timeout", req_valid & m, 0);
    endtask

    task automatic wait_obs(input int tgt);
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            if (obs_id.size() >= tgt) begin
                #1;
                return;
            end
        end
        check("rsp_timeout", obs_id.size(), tgt);
        #1;
    endtask

    task automatic wait_rsp_vld();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid) return;
        end
        check("rsp_valid_timeout", rsp_valid, 1);
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        int tgt;
        tgt = obs_id.size() + 1;
        set_op(i, a, b, c);
        wait_drop(NREQ'(1) << i);
        wait_obs(tgt);
    endtask

    function automatic int oid(input int k);
        return (obs_id.size() > k) ? obs_id[k] : -1;
    endfunction

    function automatic logic [31:0] ores(input int k);
        return (obs_res.size() > k) ? obs_res[k] : 32'hDEAD_BEEF;
    endfunction

    int base;
    int exp_ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single add from requester 0: grant at T, response at T+2.
        rsp_ready = 1'b1;
        set_op(0, 32'd5, 32'd7, 3'b010);
        @(negedge clk);
        check("t1_grant", req_ready, 4'b0001);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        check("t1_T1_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("t1_T2_rsp_valid", rsp_valid, 1);
        check("t1_id", rsp_id, 0);
        check("t1_result", rsp_result, 32'd12);
        check("t1_zero", rsp_zero, 0);
        check("t1_err", rsp_err, 0);
        @(posedge clk);
        #1;

        // Sub to zero, and unsigned slt in both directions.
        base = obs_id.size();
        issue(2, 32'd9, 32'd9, 3'b110);
        issue(3, 32'd3, 32'd8, 3'b111);
        issue(3, 32'hFFFF_FFFF, 32'd1, 3'b111);
        check("t2_sub_res", ores(base), 0);
        check("t2_sub_zero", (obs_z.size() > base) ? obs_z[base] : 1'bx, 1);
        check("t2_slt_lt", ores(base + 1), 1);
        check("t2_slt_unsigned", ores(base + 2), 0);

        // All four requesters continuously valid from pointer 0.
        base = obs_id.size();
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(i * 16), 32'd1, 3'b010);
        begin
            int n;
            for (n = 0; n < 300; n++) begin
                @(posedge clk);
                if (obs_id.size() >= base + 5) break;
            end
            if (n == 300) check("rr_timeout", obs_id.size(), base + 5);
        end
        #1 req_valid = '0;
        for (int k = 0; k < 5; k++) check("rr_order", oid(base + k), exp_ord[k]);
        check("rr_res0", ores(base), 32'd1);
        check("rr_res1", ores(base + 1), 32'd17);

        // Backpressure: response held for 5 cycles while another request waits.
        base = obs_id.size();
        rsp_ready = 1'b0;
        set_op(0, 32'hF0, 32'h3C, 3'b000);
        wait_drop(4'b0001);
        wait_rsp_vld();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) set_op(2, 32'd1, 32'd2, 3'b010);
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_result", rsp_result, 32'h30);
            check("bp_ready_low", req_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_busy", busy, 0);
        check("bp_idle_grant", req_ready, 4'b0100);
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        wait_obs(base + 2);
        check("bp_obs_res", ores(base), 32'h30);
        check("bp_next_res", ores(base + 1), 32'd3);

        // Illegal control code.
        base = obs_id.size();
        issue(1, 32'h1234, 32'h5678, 3'b011);
        check("ill_id", oid(base), 1);
        check("ill_err", (obs_e.size() > base) ? obs_e[base] : 1'bx, 1);
        check("ill_res", ores(base), 0);
        check("ill_zero", (obs_z.size() > base) ? obs_z[base] : 1'bx, 1);

        // Reset while a response is pending.
        rsp_ready = 1'b0;
        set_op(2, 32'd4, 32'd4, 3'b010);
        wait_drop(4'b0100);
        wait_rsp_vld();
        check("mid_pre_id", rsp_id, 2);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_result", rsp_result, 0);
        check("mid_id", rsp_id, 0);
        check("mid_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        rsp_ready = 1'b1;
        base = obs_id.size();
        set_op(1, 32'd2, 32'd3, 3'b001);
        set_op(3, 32'd8, 32'd1, 3'b110);
        wait_drop(4'b1010);
        wait_obs(base + 2);
        check("post_rst_first_id", oid(base), 1);
        check("post_rst_second_id", oid(base + 1), 3);
        check("post_rst_or", ores(base), 32'd3);
        check("post_rst_sub", ores(base + 1), 32'd7);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
        $finish;
    end

endmodule
